nand_logic_pipe: RTL and testbench
==================================

Name: nand_logic_pipe

Overview:
- Parametrised, pipelined bitwise logic unit; successor to the 2-input single-bit NAND-built gates.
- Operates on WIDTH-bit operand pairs with a 3-bit op select; every function is built structurally from 2-input NAND cells.
- Elastic valid/ready pipeline of STAGES register stages, plus a saturating completed-transaction counter.
- Sits between a stimulus/source block and any consumer that may apply backpressure.

Parameters:
- WIDTH, 8, operand/result width in bits (1..64)
- STAGES, 2, pipeline register stages (1..4); latency in cycles
- CNT_W, 16, width of completed-transaction counter

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair and op present
- in_ready  output  1  block accepts input this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- op  input  3  function select
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result this cycle
- Z  output  WIDTH  result
- op_out  output  3  op that produced Z
- zero  output  1  Z == 0 (valid only with out_valid)
- parity  output  1  XOR-reduction of Z
- done_cnt  output  CNT_W  number of completed output transfers

Behaviour:
- Op encoding, bitwise: 000 AND, 001 NAND, 010 OR, 011 NOR, 100 XOR, 101 XNOR, 110 NOT A (B ignored), 111 PASS A.
- Combinational function uses only NAND2 instances; no direct &, |, ^ in the datapath. zero and parity are computed from registered Z in the final stage.
- Pipeline:
  - Stage k holds valid_k, Z_k and op_k. The function result is registered into stage 0; stages 1..STAGES-1 are pure registers.
  - Last stage drives out_valid, Z, op_out.
- Advance rule: stage k loads from its upstream when (!valid_k || stage k+1 accepts). The last stage accepts when (!out_valid || out_ready).
- in_ready = stage 0 can load. A transfer occurs when in_valid && in_ready.
- Latency: an accepted input appears on out_valid exactly STAGES cycles later if out_ready has been held high.
- Throughput: one result per cycle with no backpressure.
- Backpressure:
  - While out_valid && !out_ready, Z, op_out, zero and parity hold stable.
  - Full pipeline: in_ready is low once all stages are valid and out_ready is low.
  - No transaction is lost or duplicated. Ordering is strictly FIFO.
- in_ready may depend combinationally on out_ready (no skid buffer). in_valid must not depend on in_ready.
- done_cnt:
  - Increments on each out_valid && out_ready cycle.
  - Saturates at 2^CNT_W-1; no wrap.
- Reset, including mid-operation:
  - All valid bits, Z, op_out, zero, parity and done_cnt clear to 0 on the first clock edge with rst high.
  - In-flight data is discarded.
  - in_ready is low while rst is high and high on the first cycle after rst deasserts.
- Inputs are ignored while rst is high.
- Undefined op is impossible: all 8 codes are defined.

Test Plan:
- Exhaustive truth table, WIDTH=1, STAGES=1, out_ready=1: all 8 ops × 4 (A,B) combinations.
  - Expected for A=1, B=0: AND 0, NAND 1, OR 1, NOR 0, XOR 1, XNOR 0, NOT 0, PASS 1.
  - Each result arrives 1 cycle after acceptance.
- WIDTH=8, STAGES=2: stream A=8'hF0, B=8'h3C with ops 000..111 on consecutive cycles.
  - Expected Z sequence: 30, CF, FC, 03, CC, 33, 0F, F0.
  - out_valid follows in_valid by 2 cycles. op_out matches each op.
  - zero=0 throughout. parity for XOR result 8'hCC = 0.
- Backpressure: hold out_ready=0 for 5 cycles while sending 4 transactions.
  - in_ready drops after 2 accepts (STAGES=2).
  - Z stays stable.
  - On release, results drain in order with no loss; done_cnt ends at 4.
- Zero flag: A=8'hAA, B=8'h55, op=000.
  - Expected: Z=00, zero=1, parity=0.
- Saturation: CNT_W=3, 10 transfers.
  - Expected: done_cnt stops at 7.
- Reset mid-stream: assert rst for 1 cycle with 2 transactions in flight.
  - Next cycle: out_valid=0, done_cnt=0, Z=0.
  - Flushed data never appears.
  - in_ready=1 on the cycle after rst deasserts.

Source files
------------

// File: rtl/nand_logic_pipe.sv
// rtl/nand_logic_pipe.sv - pipelined NAND2-built bitwise logic unit with elastic valid/ready stages
module nand_logic_pipe #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Z,
   output logic [2:0]       op_out,
   output logic             zero,
   output logic             parity,
   output logic [CNT_W-1:0] done_cnt
);

   localparam int LAST = STAGES - 1;

   logic [WIDTH-1:0] f_and, f_nand, f_or, f_nor, f_xor, f_xnor, f_not, f_pass;
   logic [WIDTH-1:0] n_b, n_x1, n_x2;
   logic [WIDTH-1:0] fn_z;

   // Every function is a small network of NAND2 cells, one network per bit.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      nand2 u_ab   (.a(A[i]),      .b(B[i]),      .y(f_nand[i]));
      nand2 u_aa   (.a(A[i]),      .b(A[i]),      .y(f_not[i]));
      nand2 u_bb   (.a(B[i]),      .b(B[i]),      .y(n_b[i]));
      nand2 u_and  (.a(f_nand[i]), .b(f_nand[i]), .y(f_and[i]));
      nand2 u_or   (.a(f_not[i]),  .b(n_b[i]),    .y(f_or[i]));
      nand2 u_nor  (.a(f_or[i]),   .b(f_or[i]),   .y(f_nor[i]));
      nand2 u_x1   (.a(A[i]),      .b(f_nand[i]), .y(n_x1[i]));
      nand2 u_x2   (.a(B[i]),      .b(f_nand[i]), .y(n_x2[i]));
      nand2 u_xor  (.a(n_x1[i]),   .b(n_x2[i]),   .y(f_xor[i]));
      nand2 u_xnor (.a(f_xor[i]),  .b(f_xor[i]),  .y(f_xnor[i]));
      nand2 u_pass (.a(f_not[i]),  .b(f_not[i]),  .y(f_pass[i]));
   end

   // Op select only steers between the NAND-built results.
   always_comb begin
      fn_z = '0;
      case (op)
         3'b000:  fn_z = f_and;
         3'b001:  fn_z = f_nand;
         3'b010:  fn_z = f_or;
         3'b011:  fn_z = f_nor;
         3'b100:  fn_z = f_xor;
         3'b101:  fn_z = f_xnor;
         3'b110:  fn_z = f_not;
         default: fn_z = f_pass;
      endcase
   end

   logic [STAGES-1:0] valid_q;
   logic [STAGES-1:0] load;
   logic [WIDTH-1:0]  z_q [STAGES];
   logic [2:0]        op_q [STAGES];
   logic [STAGES-1:0] stage_v_in;
   logic [WIDTH-1:0]  stage_z_in [STAGES];
   logic [2:0]        stage_op_in [STAGES];
   logic              zero_q, parity_q;
   logic [CNT_W-1:0]  cnt_q;

   // A stage can load unless it and every stage downstream are full while the consumer stalls.
   always_comb begin
      logic blocked;
      blocked = !out_ready;
      load    = '0;
      for (int k = LAST; k >= 0; k--) begin
         blocked = blocked && valid_q[k];
         load[k] = !blocked;
      end
   end

   // Stage 0 is fed by the logic function, later stages by their predecessor.
   always_comb begin
      stage_v_in     = '0;
      stage_v_in[0]  = in_valid;
      stage_z_in[0]  = fn_z;
      stage_op_in[0] = op;
      for (int k = 1; k < STAGES; k++) begin
         stage_v_in[k]  = valid_q[k-1];
         stage_z_in[k]  = z_q[k-1];
         stage_op_in[k] = op_q[k-1];
      end
   end

   // Pipeline advance, output flags and saturating completion counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= '0;
         zero_q   <= 1'b0;
         parity_q <= 1'b0;
         cnt_q    <= '0;
         for (int k = 0; k < STAGES; k++) begin
            z_q[k]  <= '0;
            op_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (load[k]) begin
               valid_q[k] <= stage_v_in[k];
               if (stage_v_in[k]) begin
                  z_q[k]  <= stage_z_in[k];
                  op_q[k] <= stage_op_in[k];
               end
            end
         end
         if (load[LAST] && stage_v_in[LAST]) begin
            zero_q   <= (stage_z_in[LAST] == '0);
            parity_q <= ^stage_z_in[LAST];
         end
         if (valid_q[LAST] && out_ready && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign in_ready  = load[0] && !rst;
   assign out_valid = valid_q[LAST];
   assign Z         = z_q[LAST];
   assign op_out    = op_q[LAST];
   assign zero      = zero_q;
   assign parity    = parity_q;
   assign done_cnt  = cnt_q;

endmodule

// Two-input NAND cell, the only logic primitive used by the function network.
module nand2 (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = ~(a & b);
endmodule

// File: tb/tb_nand_logic_pipe.sv
// tb/tb_nand_logic_pipe.sv - scoreboard bench for nand_logic_pipe
module tb_nand_logic_pipe;

   localparam int W = 8;
   localparam int S = 2;
   localparam int C = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         in_valid, in_ready, out_valid, out_ready, zero, parity;
   logic [W-1:0] A, B, Z;
   logic [2:0]   op, op_out;
   logic [C-1:0] done_cnt;

   logic         in_valid1, in_ready1, out_valid1, out_ready1, zero1, parity1;
   logic [0:0]   A1, B1, Z1;
   logic [2:0]   op1, op_out1;
   logic [15:0]  done_cnt1;

   nand_logic_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(C)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .Z(Z), .op_out(op_out), .zero(zero), .parity(parity), .done_cnt(done_cnt)
   );

   nand_logic_pipe #(.WIDTH(1), .STAGES(1), .CNT_W(16)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
      .A(A1), .B(B1), .op(op1), .out_valid(out_valid1), .out_ready(out_ready1),
      .Z(Z1), .op_out(op_out1), .zero(zero1), .parity(parity1), .done_cnt(done_cnt1)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] ref_fn(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
      case (o)
         3'd0:    return a & b;
         3'd1:    return ~(a & b);
         3'd2:    return a | b;
         3'd3:    return ~(a | b);
         3'd4:    return a ^ b;
         3'd5:    return ~(a ^ b);
         3'd6:    return ~a;
         default: return a;
      endcase
   endfunction

   typedef struct {
      logic [7:0] z;
      logic [2:0] op;
      int         cyc;
   } exp_t;

   exp_t q[$];
   exp_t q1[$];

   logic [7:0] seq_f0 [8] = '{8'h30, 8'hCF, 8'hFC, 8'h03, 8'hCC, 8'h33, 8'h0F, 8'hF0};
   logic [7:0] tt_a1b0 = 8'h96;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Input observers: record the expected result of every accepted transfer.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && in_valid && in_ready) begin
         e.z   = (A == 8'hF0 && B == 8'h3C) ? seq_f0[op] : ref_fn(op, A, B);
         e.op  = op;
         e.cyc = cyc;
         q.push_back(e);
      end
      if (!rst && in_valid1 && in_ready1) begin
         e.z   = (A1 == 1'b1 && B1 == 1'b0) ? {7'd0, tt_a1b0[op1]} : {7'd0, ref_fn(op1, {7'd0, A1}, {7'd0, B1})[0]};
         e.op  = op1;
         e.cyc = cyc;
         q1.push_back(e);
      end
   end

   int          exp_cnt = 0;
   int          last_bp = -1;
   logic        rst_d   = 1'b0;
   logic        hold    = 1'b0;
   logic [13:0] saved;

   // Output monitor for the main instance.
   always @(negedge clk) begin
      exp_t e;
      if (rst_d) chk("reset_clear", {out_valid, Z, op_out, zero, parity, done_cnt}, '0);
      if (rst) begin
         chk("in_ready_in_rst", in_ready, 1'b0);
         q.delete();
         exp_cnt = 0;
         hold    = 1'b0;
      end else begin
         if (rst_d) chk("in_ready_after_rst", in_ready, 1'b1);
         chk("done_cnt", done_cnt, exp_cnt);
         if (hold) chk("hold_stable", {out_valid, Z, op_out, zero, parity}, saved);
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_out", Z, 'x);
            end else begin
               e = q.pop_front();
               chk("z", Z, e.z);
               chk("op_out", op_out, e.op);
               chk("zero", zero, e.z == 8'h00);
               chk("parity", parity, ^e.z);
               if (last_bp < e.cyc) chk("latency", cyc - e.cyc, S);
               else chk("latency_min", (cyc - e.cyc) >= S, 1'b1);
            end
            exp_cnt = (exp_cnt == 7) ? 7 : exp_cnt + 1;
         end
         hold  = out_valid && !out_ready;
         saved = {out_valid, Z, op_out, zero, parity};
         if (!out_ready) last_bp = cyc;
      end
      rst_d = rst;
   end

   // Output monitor for the single-bit, single-stage instance.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         q1.delete();
      end else if (out_valid1) begin
         if (q1.size() == 0) begin
            chk("tt_unexpected_out", Z1, 'x);
         end else begin
            e = q1.pop_front();
            chk("tt_z", Z1, e.z[0]);
            chk("tt_op_out", op_out1, e.op);
            chk("tt_latency", cyc - e.cyc, 1);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o);
      int   n  = 0;
      logic ok = 1'b0;
      in_valid = 1'b1;
      A = a; B = b; op = o;
      while (!ok && n < 50) begin
         @(negedge clk);
         ok = in_ready;
         tick();
         n++;
      end
      in_valid = 1'b0;
      if (!ok) chk("send_timeout", ok, 1'b1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (q.size() > 0 && n < 50) begin
         tick();
         n++;
      end
      tick();
      chk("drain_empty", q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; op = '0;
      in_valid1 = 1'b0; out_ready1 = 1'b1; A1 = '0; B1 = '0; op1 = '0;
      tick(); tick();
      rst = 1'b0;
      tick();

      for (int o = 0; o < 8; o++) begin
         for (int ab = 0; ab < 4; ab++) begin
            in_valid1 = 1'b1;
            op1 = 3'(o);
            A1  = 1'(ab >> 1);
            B1  = 1'(ab);
            tick();
         end
      end
      in_valid1 = 1'b0;
      tick(); tick();

      for (int o = 0; o < 8; o++) send(8'hF0, 8'h3C, 3'(o));
      send(8'hAA, 8'h55, 3'd0);
      drain();

      do_reset();
      out_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 5; i++) begin
         in_valid = (acc < 4);
         A = 8'h11 * 8'(acc + 1); B = 8'h5A; op = 3'(acc + 2);
         @(negedge clk);
         if (in_valid && in_ready) acc++;
         tick();
      end
      in_valid = 1'b0;
      chk("accepts_under_bp", acc, 2);
      out_ready = 1'b1;
      for (int i = acc; i < 4; i++) send(8'h11 * 8'(i + 1), 8'h5A, 3'(i + 2));
      drain();
      chk("done_cnt_after_bp", done_cnt, 4);

      do_reset();
      for (int i = 0; i < 10; i++) send(8'($urandom), 8'($urandom), 3'($urandom));
      drain();
      chk("done_cnt_saturated", done_cnt, 7);

      do_reset();
      send(8'hC3, 8'h0F, 3'd4);
      send(8'h12, 8'h34, 3'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick(); tick(); tick();

      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom % 2) == 0;
         out_ready = ($urandom % 4) != 0;
         A  = 8'($urandom);
         B  = ($urandom % 8 == 0) ? ~A : 8'($urandom);
         op = 3'($urandom);
         if (i == 200) rst = 1'b1;
         if (i == 201) rst = 1'b0;
         tick();
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
